// File: rtl/parser_pkg.sv
// Shared parser types: the type-lookup rule entry, its word packing,
// and the rule-loader opcode / status / state encodings.
package parser_pkg;

    localparam int RULE_NUM = 8;

    typedef struct packed {
        logic        typeRule_valid;
        logic [15:0] typeRule_typeData;
        logic [15:0] typeRule_typeMask;
        logic [7:0]  typeRule_offset;
        logic [7:0]  typeRule_nextState;
        logic [15:0] typeRule_headerLength;
    } type_rule_t;

    localparam int TYPE_RULE_BITS  = $bits(type_rule_t);
    localparam int TYPE_RULE_WORDS = (TYPE_RULE_BITS + 31) / 32;

    typedef enum logic [3:0] {
        LDR_WRITE = 4'd1,
        LDR_READ  = 4'd2,
        LDR_CLEAR = 4'd3
    } ldr_op_e;

    typedef enum logic [7:0] {
        LDR_OK      = 8'd0,
        LDR_BAD_IDX = 8'd1,
        LDR_BAD_OP  = 8'd2
    } ldr_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT,
        ST_CLEAR,
        ST_ACK,
        ST_RDATA
    } ldr_state_e;

    function automatic logic [31:0] ldr_ack(input logic [3:0] op,
                                            input logic [7:0] st,
                                            input logic [7:0] idx);
        return {4'hA, op, st, 8'h00, idx};
    endfunction

endpackage

// File: rtl/rule_shadow_ram.sv
// Shadow store of every rule slot: one synchronous write port and one
// read port with a one-cycle registered read.
// Ports: clk, we/wr_addr/wr_data (write), rd_addr -> rd_data (next cycle).
module rule_shadow_ram
    import parser_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  type_rule_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output type_rule_t    rd_data
);

    type_rule_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/type_rule_loader.sv
// Assembles type_rule_t entries from a 32-bit command stream, writes them
// to a lookup stage via a one-hot strobe, and serves read-back / clear-all.
// Ports: i_clk, i_rst (sync, active high); i_cmd_data/i_cmd_valid/o_cmd_ready
// command in; o_rsp_data/o_rsp_valid/i_rsp_ready response out;
// o_rule_wren/o_type_rule rule write port; o_busy (not IDLE).
module type_rule_loader
    import parser_pkg::*;
#(
    parameter int RULE_NUM  = parser_pkg::RULE_NUM,
    parameter int CMD_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CMD_WIDTH-1:0] i_cmd_data,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    output logic [CMD_WIDTH-1:0] o_rsp_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [RULE_NUM-1:0]  o_rule_wren,
    output type_rule_t           o_type_rule,
    output logic                 o_busy
);

    localparam int W   = TYPE_RULE_WORDS * 32;
    localparam int WCW = $clog2(TYPE_RULE_WORDS + 1);
    localparam int AW  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
    localparam logic [8:0]     NSLOT     = 9'(RULE_NUM);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(TYPE_RULE_WORDS - 1);
    localparam logic [7:0]     LAST_SLOT = 8'(RULE_NUM - 1);

    ldr_state_e    state;
    logic [3:0]    op;
    logic [7:0]    status;
    logic [7:0]    idx;
    logic [7:0]    ccnt;
    logic [WCW-1:0] cnt;
    logic [W-1:0]  buf_q;
    logic [RULE_NUM-1:0] written;

    logic          cmd_fire;
    logic          rsp_fire;
    logic [3:0]    hop;
    logic [7:0]    hidx;
    logic          hidx_ok;
    logic          idx_ok;
    ldr_status_e   hst;
    logic [W-1:0]  shifted;
    logic [W-1:0]  padded;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    type_rule_t    rd_rule;

    assign o_cmd_ready = !i_rst && (state == ST_IDLE || state == ST_COLLECT);
    assign o_busy      = (state != ST_IDLE);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign rsp_fire    = o_rsp_valid && i_rsp_ready;
    assign hop         = i_cmd_data[31:28];
    assign hidx        = i_cmd_data[7:0];
    assign hidx_ok     = {1'b0, hidx} < NSLOT;
    assign idx_ok      = {1'b0, idx} < NSLOT;
    assign shifted     = {i_cmd_data, buf_q[W-1:32]};

    // Read address follows the header in IDLE so the entry is already
    // registered by the time ACK completes.
    assign rd_addr = (state == ST_IDLE) ? hidx[AW-1:0] : idx[AW-1:0];
    assign wr_addr = (state == ST_CLEAR) ? ccnt[AW-1:0] : idx[AW-1:0];

    // Never-written slots read back as zero regardless of RAM contents.
    assign padded = W'(rd_rule) & {W{written[idx[AW-1:0]]}};

    always_comb begin
        hst = LDR_OK;
        if (!(hop inside {LDR_WRITE, LDR_READ, LDR_CLEAR}))
            hst = LDR_BAD_OP;
        else if (hop == LDR_READ && !hidx_ok)
            hst = LDR_BAD_IDX;
    end

    rule_shadow_ram #(.DEPTH(RULE_NUM), .AW(AW)) u_shadow (
        .clk     (i_clk),
        .we      ((|o_rule_wren) && !i_rst),
        .wr_addr (wr_addr),
        .wr_data (o_type_rule),
        .rd_addr (rd_addr),
        .rd_data (rd_rule)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            op          <= '0;
            status      <= '0;
            idx         <= '0;
            ccnt        <= '0;
            cnt         <= '0;
            buf_q       <= '0;
            written     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rule_wren <= '0;
            o_type_rule <= '0;
        end else begin
            // The strobe issued last cycle lands in written[] now.
            if (|o_rule_wren) written[wr_addr] <= (state == ST_COMMIT);

            unique case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op     <= hop;
                        idx    <= hidx;
                        status <= hst;
                        cnt    <= '0;
                        ccnt   <= '0;
                        if (hop == LDR_WRITE) begin
                            state <= ST_COLLECT;
                        end else if (hop == LDR_CLEAR) begin
                            state       <= ST_CLEAR;
                            o_rule_wren <= RULE_NUM'(1);
                            o_type_rule <= '0;
                        end else begin
                            state       <= ST_ACK;
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= ldr_ack(hop, hst, hidx);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cmd_fire) begin
                        buf_q <= shifted;
                        cnt   <= cnt + WCW'(1);
                        if (cnt == LAST_WORD) begin
                            cnt <= '0;
                            if (idx_ok) begin
                                state       <= ST_COMMIT;
                                o_rule_wren <= RULE_NUM'(1) << idx[AW-1:0];
                                o_type_rule <= shifted[TYPE_RULE_BITS-1:0];
                            end else begin
                                state       <= ST_ACK;
                                status      <= LDR_BAD_IDX;
                                o_rsp_valid <= 1'b1;
                                o_rsp_data  <= ldr_ack(op, LDR_BAD_IDX, idx);
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    o_rule_wren <= '0;
                    o_type_rule <= '0;
                    state       <= ST_ACK;
                    o_rsp_valid <= 1'b1;
                    o_rsp_data  <= ldr_ack(op, LDR_OK, idx);
                end
                ST_CLEAR: begin
                    if (ccnt == LAST_SLOT) begin
                        o_rule_wren <= '0;
                        state       <= ST_ACK;
                        o_rsp_valid <= 1'b1;
                        o_rsp_data  <= ldr_ack(op, LDR_OK, idx);
                    end else begin
                        ccnt        <= ccnt + 8'd1;
                        o_rule_wren <= o_rule_wren << 1;
                    end
                end
                ST_ACK: begin
                    if (rsp_fire) begin
                        if (op == LDR_READ && status == LDR_OK) begin
                            state      <= ST_RDATA;
                            cnt        <= '0;
                            o_rsp_data <= padded[31:0];
                            buf_q      <= padded >> 32;
                        end else begin
                            state       <= ST_IDLE;
                            o_rsp_valid <= 1'b0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rsp_fire) begin
                        if (cnt == LAST_WORD) begin
                            state       <= ST_IDLE;
                            cnt         <= '0;
                            o_rsp_valid <= 1'b0;
                        end else begin
                            cnt        <= cnt + WCW'(1);
                            o_rsp_data <= buf_q[31:0];
                            buf_q      <= buf_q >> 32;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_type_rule_loader.sv
// Self-checking bench for type_rule_loader: directed scenarios plus a
// randomized command mix checked against an array-based rule model.
module tb_type_rule_loader;

    localparam int NR = 8;
    localparam int RB = parser_pkg::TYPE_RULE_BITS;
    localparam int NW = parser_pkg::TYPE_RULE_WORDS;
    localparam int MW = NW * 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cmd_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   rsp_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [NR-1:0] wren;
    parser_pkg::type_rule_t trule;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int wcount = 0;
    int onehot_err = 0;

    logic [MW-1:0] mrule [NR];
    bit            mwr [NR];
    logic [MW-1:0] rmask;

    type_rule_loader #(.RULE_NUM(NR), .CMD_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_data  (cmd_data),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rule_wren (wren),
        .o_type_rule (trule),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|wren) wcount++;
        if (!$onehot0(wren)) onehot_err++;
    end

    function automatic logic [31:0] exp_ack(input logic [3:0] op,
                                            input logic [7:0] idx);
        logic [7:0] st;
        if (op < 4'd1 || op > 4'd3) st = 8'd2;
        else if (op != 4'd3 && idx >= 8'(NR)) st = 8'd1;
        else st = 8'd0;
        return {4'hA, op, st, 8'h00, idx};
    endfunction

    function automatic logic [MW-1:0] exp_rule(input int i);
        return mwr[i] ? mrule[i] : '0;
    endfunction

    task automatic send_cmd(input logic [31:0] w, input int gapmax);
        int n;
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = w;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL cmd_accept got ready=0 want 1 word=%h", w);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = $urandom;
    endtask

    task automatic get_rsp(input bit thr, output logic [31:0] d);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            failures++;
            $display("FAIL rsp_wait got valid=0 want 1");
        end
        d = rsp_data;
        if (thr) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== d) begin
                    failures++;
                    $display("FAIL rsp_hold got %h/%b want %h/1",
                             rsp_data, rsp_valid, d);
                end
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] idx, input logic [MW-1:0] p,
                              input int gap);
        send_cmd({4'h1, 20'($urandom), idx}, gap);
        for (int k = 0; k < NW; k++) send_cmd(p[32*k +: 32], gap);
    endtask

    task automatic model_write(input logic [7:0] idx, input logic [MW-1:0] p);
        if (idx < 8'(NR)) begin
            mrule[idx] = p & rmask;
            mwr[idx] = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL rst_ready got %b want 0", cmd_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
        end
        checks++;
        if (wren !== '0) begin
            failures++; $display("FAIL rst_wren got %h want 0", wren);
        end
        checks++;
        if (busy !== 1'b0 || trule !== '0) begin
            failures++; $display("FAIL rst_busy_rule got %b/%h want 0/0", busy, trule);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL post_rst_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write;
        logic [MW-1:0] p;
        logic [31:0] d;
        p = {$urandom, $urandom, $urandom};
        send_write(8'd3, p, 0);
        checks++;
        if (wren !== 8'h08 || trule !== p[RB-1:0]) begin
            failures++;
            $display("FAIL write_strobe got %h/%h want 08/%h", wren, trule, p[RB-1:0]);
        end
        @(negedge clk);
        checks++;
        if (wren !== '0 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_timing got wren=%h valid=%b want 00/1", wren, rsp_valid);
        end
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA1000003) begin
            failures++; $display("FAIL write_ack got %h want A1000003", d);
        end
        model_write(8'd3, p);
    endtask

    task automatic test_read;
        logic [31:0] d;
        logic [MW-1:0] e;
        for (int s = 3; s <= 5; s += 2) begin
            send_cmd({4'h2, 20'h0, 8'(s)}, 0);
            get_rsp(1'b0, d);
            checks++;
            if (d !== {24'hA20000, 8'(s)}) begin
                failures++; $display("FAIL read_ack slot %0d got %h want %h", s, d, {24'hA20000, 8'(s)});
            end
            e = exp_rule(s);
            for (int k = 0; k < NW; k++) begin
                get_rsp(1'b0, d);
                checks++;
                if (d !== e[32*k +: 32]) begin
                    failures++;
                    $display("FAIL read_word slot %0d w%0d got %h want %h", s, k, d, e[32*k +: 32]);
                end
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++; $display("FAIL read_extra got valid=1 want 0");
            end
        end
    endtask

    task automatic test_bad_index;
        int c0;
        logic [31:0] d;
        c0 = wcount;
        send_write(8'd9, {$urandom, $urandom, $urandom}, 1);
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA1010009) begin
            failures++; $display("FAIL badidx_ack got %h want A1010009", d);
        end
        checks++;
        if (wcount !== c0) begin
            failures++; $display("FAIL badidx_wren got %0d strobes want 0", wcount - c0);
        end
    endtask

    task automatic test_bad_opcode;
        logic [31:0] d;
        send_cmd(32'h70000000, 0);
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA7020000) begin
            failures++; $display("FAIL badop_ack got %h want A7020000", d);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL badop_next_ready got %b want 1", cmd_ready);
        end
        send_cmd(32'h70000000 | 32'h0000000F, 0);
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA702000F) begin
            failures++; $display("FAIL badop_back2back got %h want A702000F", d);
        end
    endtask

    task automatic test_clear;
        logic [31:0] d;
        send_cmd(32'h30000000, 0);
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (wren !== NR'(1 << i) || trule !== '0) begin
                failures++;
                $display("FAIL clear_walk step %0d got %h/%h want %h/0", i, wren, trule, NR'(1 << i));
            end
            @(negedge clk);
        end
        checks++;
        if (wren !== '0 || rsp_valid !== 1'b1) begin
            failures++; $display("FAIL clear_end got wren=%h valid=%b want 00/1", wren, rsp_valid);
        end
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA3000000) begin
            failures++; $display("FAIL clear_ack got %h want A3000000", d);
        end
        for (int i = 0; i < NR; i++) mwr[i] = 1'b0;
        for (int s = 0; s < NR; s++) begin
            send_cmd({4'h2, 20'h0, 8'(s)}, 0);
            get_rsp(1'b0, d);
            for (int k = 0; k < NW; k++) begin
                get_rsp(1'b0, d);
                checks++;
                if (d !== 32'h0) begin
                    failures++; $display("FAIL clear_read slot %0d got %h want 0", s, d);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [MW-1:0] p;
        logic [MW-1:0] e;
        logic [7:0] idx;
        logic [3:0] op;
        int r;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            idx = 8'($urandom_range(0, 9));
            if (r < 4) begin
                op = 4'h1;
                p = {$urandom, $urandom, $urandom};
                send_write(idx, p, 2);
                model_write(idx, p);
            end else if (r < 8) begin
                op = 4'h2;
                send_cmd({op, 20'($urandom), idx}, 2);
            end else if (r == 8) begin
                op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15));
                send_cmd({op, 20'($urandom), idx}, 2);
            end else begin
                op = 4'h3;
                idx = 8'($urandom);
                send_cmd({op, 20'($urandom), idx}, 2);
                for (int i = 0; i < NR; i++) mwr[i] = 1'b0;
            end
            get_rsp(1'b1, d);
            checks++;
            if (d !== exp_ack(op, idx)) begin
                failures++;
                $display("FAIL rand_ack it %0d got %h want %h", it, d, exp_ack(op, idx));
            end
            if (op == 4'h2 && idx < 8'(NR)) begin
                e = exp_rule(int'(idx));
                for (int k = 0; k < NW; k++) begin
                    get_rsp(1'b1, d);
                    checks++;
                    if (d !== e[32*k +: 32]) begin
                        failures++;
                        $display("FAIL rand_read it %0d w%0d got %h want %h", it, k, d, e[32*k +: 32]);
                    end
                end
            end
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rand_done it %0d got valid=%b busy=%b want 0/0", it, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        logic [31:0] d;
        logic [MW-1:0] p;
        c0 = wcount;
        send_cmd({4'h1, 20'h0, 8'd2}, 0);
        send_cmd($urandom, 0);
        send_cmd($urandom, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wren !== '0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_in got wren=%h valid=%b ready=%b want 0/0/0", wren, rsp_valid, cmd_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < NR; i++) mwr[i] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wcount !== c0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after got strobes=%0d valid=%b busy=%b want 0/0/0", wcount - c0, rsp_valid, busy);
        end
        p = {$urandom, $urandom, $urandom};
        send_write(8'd0, p, 0);
        checks++;
        if (wren !== 8'h01 || trule !== p[RB-1:0]) begin
            failures++; $display("FAIL midrst_write got %h/%h want 01/%h", wren, trule, p[RB-1:0]);
        end
        get_rsp(1'b0, d);
        checks++;
        if (d !== 32'hA1000000) begin
            failures++; $display("FAIL midrst_ack got %h want A1000000", d);
        end
        model_write(8'd0, p);
        send_cmd(32'h20000003, 0);
        get_rsp(1'b0, d);
        for (int k = 0; k < NW; k++) begin
            get_rsp(1'b0, d);
            checks++;
            if (d !== 32'h0) begin
                failures++; $display("FAIL midrst_masked w%0d got %h want 0", k, d);
            end
        end
    endtask

    task automatic test_onehot;
        checks++;
        if (onehot_err !== 0) begin
            failures++; $display("FAIL wren_onehot got %0d bad cycles want 0", onehot_err);
        end
    endtask

    initial begin
        rmask = '0;
        for (int b = 0; b < RB; b++) rmask[b] = 1'b1;
        for (int i = 0; i < NR; i++) begin
            mrule[i] = '0;
            mwr[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_bad_index();
        test_bad_opcode();
        test_clear();
        test_write();
        test_random();
        test_reset_mid();
        test_onehot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/type_rule_loader.md
# type_rule_loader

Control-plane writer for the parser's type-lookup rule tables. It accepts a 32-bit command stream over valid/ready and assembles full `type_rule_t` entries from several words. It then drives the rule-write port of one lookup stage: a one-hot `wren` vector plus the rule struct. It keeps a shadow copy of every rule so that software can read rules back and clear all of them.

## Interface
Parameters:
- `RULE_NUM`, default `parser_pkg::RULE_NUM`: number of rule slots in the target lookup stage; must be ≤ 256.
- `CMD_WIDTH`, default 32: command and response word width; only 32 is supported.

Ports:
- `i_clk`, input, 1: single clock; all logic is on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_cmd_data`, input, 32: command/payload word.
- `i_cmd_valid`, input, 1: command word valid.
- `o_cmd_ready`, output, 1: block accepts `i_cmd_data` this cycle.
- `o_rsp_data`, output, 32: response word.
- `o_rsp_valid`, output, 1: response word valid.
- `i_rsp_ready`, input, 1: downstream accepts the response word.
- `o_rule_wren`, output, `RULE_NUM`: one-hot write strobe to the lookup stage.
- `o_type_rule`, output, `type_rule_t`: rule data, qualified by `o_rule_wren`.
- `o_busy`, output, 1: high in every state except IDLE.

## Operation
- Header word format: `[31:28]` opcode, `[7:0]` rule index, all other bits ignored.
- Opcodes:
  - 1 = WRITE: header followed by `TYPE_RULE_WORDS` payload words.
  - 2 = READ.
  - 3 = CLEAR_ALL.
  - Any other value is invalid.
- Payload packing:
  - Word k carries `type_rule_t` bits `[32k+31:32k]`, least-significant word first.
  - Pad bits in the last word are ignored on write and read back as 0.
- Response (ack) word: `{4'hA, opcode[3:0], status[7:0], 8'h00, index[7:0]}`.
  - Status 0 = OK, 1 = index ≥ `RULE_NUM`, 2 = invalid opcode.
  - Exactly one ack is produced per header.
- FSM states: IDLE, COLLECT, COMMIT, CLEAR, ACK, RDATA.
- IDLE: `o_cmd_ready`=1. When a header is accepted:
  - WRITE goes to COLLECT.
  - CLEAR_ALL goes to CLEAR with the counter at 0.
  - READ and invalid opcodes go to ACK.
- COLLECT:
  - `o_cmd_ready`=1.
  - A word counter, width ⌈log2(`TYPE_RULE_WORDS`+1)⌉, shifts accepted words into an assembly register.
  - After the last word is accepted: go to COMMIT if the index is in range, else to ACK with status 1.
  - With a bad index the payload is still consumed and nothing is written.
- COMMIT (one cycle):
  - `o_rule_wren[index]`=1 and `o_type_rule`=assembled rule.
  - Shadow[index] is written and written[index] is set.
  - Next state: ACK.
- CLEAR (`RULE_NUM` cycles, i = 0..`RULE_NUM`-1):
  - `o_rule_wren`=1<<i with `o_type_rule`='0, so `typeRule_valid`=0.
  - Shadow[i] is set to 0 and written[i] is cleared.
  - Next state: ACK.
- ACK: hold the ack word until `i_rsp_ready`. Then:
  - READ with status OK goes to RDATA.
  - All other cases go to IDLE.
- RDATA:
  - Emit `TYPE_RULE_WORDS` words of shadow[index], LSW first, one per handshake, then go to IDLE.
  - A never-written slot returns all-zero words.
- `o_cmd_ready`=0 in COMMIT, CLEAR, ACK and RDATA; the upstream stalls.
- At most one bit of `o_rule_wren` is ever high, and only in COMMIT or CLEAR.

## Timing
- Reset values:
  - State is IDLE.
  - `o_cmd_ready`=0 during reset and 1 from the first cycle after reset is released.
  - `o_rsp_valid`, `o_rule_wren`, `o_type_rule`, `o_busy`, the counters and the written[] bits are all 0.
  - Shadow contents are don't-care because written[] masks them.
- WRITE latency: `o_rule_wren` is high exactly one cycle, in the cycle after the last payload handshake. `o_rsp_valid` rises the following cycle.
- CLEAR latency: the header handshake is followed by `RULE_NUM` strobe cycles. The ack is valid in the next cycle.
- The response path is registered. `o_rsp_data` and `o_rsp_valid` stay stable while `o_rsp_valid`=1 and `i_rsp_ready`=0.
- `i_cmd_valid` gaps in COLLECT only stall the collection; there is no timeout.
- Reset asserted mid-command:
  - The partial payload is discarded.
  - A pending strobe or response is dropped, and no `wren` is issued in the reset cycle.
  - The lookup stage's own reset must be driven from the same source so that its valid bits agree with written[].
- A new header is accepted in the first IDLE cycle after the final response handshake.

## Structure
- Shared in `parser_pkg`:
  - `type_rule_t` (already defined).
  - `localparam TYPE_RULE_BITS = $bits(type_rule_t)`.
  - `localparam TYPE_RULE_WORDS = (TYPE_RULE_BITS+31)/32`.
  - An opcode enum (`LDR_WRITE`=1, `LDR_READ`=2, `LDR_CLEAR`=3).
  - A status enum (`LDR_OK`, `LDR_BAD_IDX`, `LDR_BAD_OP`).
- Sub-module `rule_shadow_ram`: `RULE_NUM` × `TYPE_RULE_BITS`, one synchronous write port and one read port with a registered read. RDATA accounts for the one-cycle read latency by prefetching the shadow entry during ACK.

## Test plan
All scenarios use `RULE_NUM`=8.
- WRITE slot 3 with a payload pattern, `i_rsp_ready`=1:
  - `o_rule_wren`=8'h08 for exactly 1 cycle and `o_type_rule` equals the packed payload.
  - The ack is 0xA1000003.
- READ slot 3 after that write:
  - The ack is 0xA2000003, followed by `TYPE_RULE_WORDS` words identical to the written payload (pad bits 0).
  - READ of the never-written slot 5 returns the ack 0xA2000005 and all-zero words.
- WRITE with index 9:
  - All payload words are consumed.
  - `o_rule_wren` stays 0 throughout.
  - The ack is 0xA1010009.
- Header 0x70000000:
  - No payload is consumed.
  - The ack is 0xA7020000.
  - The next header is accepted immediately afterwards.
- CLEAR_ALL:
  - `o_rule_wren` walks 01, 02, …, 80 on consecutive cycles with `o_type_rule`=0.
  - The ack is 0xA3000000.
  - Subsequent READs return zeros.
- Throttled stall and mid-command reset:
  - With `i_rsp_ready` toggling 1/0 and `i_cmd_valid` gapped, every response word is held stable and delivered exactly once.
  - Asserting `i_rst` after 2 of `TYPE_RULE_WORDS` payload words produces no `wren` and no ack. A following complete WRITE to slot 0 gives `o_rule_wren`=8'h01 and the ack 0xA1000000.
